// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: byte-stream command decoder driving GPIO ports, clock/reset lines and a req/ack memory bus.
// Build option UART_BRIDGE_RXGAP_EN: abandon a frame whose payload stalls for more than RX_GAP cycles.
module uart_cmd_bridge #(
    parameter int NPORT   = 8,
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int ACK_TMO = 255,
    parameter int RX_GAP  = 100000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               tx_en,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic               out_clk,
    output logic               out_rst,
    input  logic [8*NPORT-1:0] in_pins,
    output logic [8*NPORT-1:0] out_pins,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic               mem_wr_req,
    output logic               mem_rd_req,
    input  logic               mem_wr_ack,
    input  logic               mem_rd_ack
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARGS     = 3'd1;
    localparam logic [2:0] S_EXEC     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_REPLY    = 3'd4;

    localparam logic [1:0] TX_READY = 2'd0;
    localparam logic [1:0] TX_RISE  = 2'd1;
    localparam logic [1:0] TX_FALL  = 2'd2;

    localparam int AB = AW / 8;
    localparam int DB = DW / 8;
    localparam int TW = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;

    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TMO - 1);
    localparam logic [3:0]    LEN_WR   = 4'(AB + DB);
    localparam logic [3:0]    LEN_RD   = 4'(AB);
    localparam logic [3:0]    REP_RD   = 4'(DB + 1);

    logic [2:0]         state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         plen_q, plen_d;
    logic [AW+DW-1:0]   args_q, args_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [DW+7:0]      rep_q, rep_d;
    logic [3:0]         rep_len_q, rep_len_d;
    logic [3:0]         rep_idx_q, rep_idx_d;
    logic [1:0]         txph_q, txph_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               out_clk_q, out_clk_d;
    logic               out_rst_q, out_rst_d;
    logic [8*NPORT-1:0] out_pins_q, out_pins_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
    logic               mem_wr_req_q, mem_wr_req_d;
    logic               mem_rd_req_q, mem_rd_req_d;
    logic               mem_hit;
`ifdef UART_BRIDGE_RXGAP_EN
    logic [31:0]        gap_q, gap_d;
`endif

    // Only the ack matching the outstanding request is honoured.
    assign mem_hit = (mem_wr_req_q && mem_wr_ack) || (mem_rd_req_q && mem_rd_ack);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        plen_d       = plen_q;
        args_d       = args_q;
        tmo_d        = tmo_q;
        rep_d        = rep_q;
        rep_len_d    = rep_len_q;
        rep_idx_d    = rep_idx_q;
        txph_d       = txph_q;
        tx_en_d      = 1'b0;
        tx_data_d    = tx_data_q;
        out_clk_d    = out_clk_q;
        out_rst_d    = out_rst_q;
        out_pins_d   = out_pins_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wr_req_d = mem_wr_req_q;
        mem_rd_req_d = mem_rd_req_q;
`ifdef UART_BRIDGE_RXGAP_EN
        gap_d        = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    // 0xFF marks an unrecognised opcode; it owes a single 0xFF reply.
                    op_d    = 8'hFF;
                    cnt_d   = '0;
                    plen_d  = '0;
                    state_d = S_EXEC;
`ifdef UART_BRIDGE_RXGAP_EN
                    gap_d   = '0;
`endif
                    case (rx_data[7:4])
                        4'h1: begin
                            if (rx_data[3:2] == 2'b00) begin
                                op_d = rx_data;
                                if (rx_data[1]) out_rst_d = ~rx_data[0];
                                else            out_clk_d = ~rx_data[0];
                            end
                        end
                        4'h2: begin
                            if (int'(rx_data[3:0]) < NPORT) op_d = rx_data;
                        end
                        4'h3: begin
                            if (int'(rx_data[3:0]) < NPORT) begin
                                op_d    = rx_data;
                                plen_d  = 4'd1;
                                state_d = S_ARGS;
                            end
                        end
                        4'hA: begin
                            if (rx_data[3:0] == 4'h0) begin
                                op_d    = rx_data;
                                plen_d  = LEN_WR;
                                state_d = S_ARGS;
                            end else if (rx_data[3:0] == 4'h1) begin
                                op_d    = rx_data;
                                plen_d  = LEN_RD;
                                state_d = S_ARGS;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_ARGS: begin
                if (rx_valid) begin
                    for (int unsigned b = 0; b < (AW + DW) / 8; b++) begin
                        if (cnt_q == 4'(b)) args_d[8*b +: 8] = rx_data;
                    end
                    cnt_d = cnt_q + 4'd1;
`ifdef UART_BRIDGE_RXGAP_EN
                    gap_d = '0;
`endif
                    if (cnt_q + 4'd1 == plen_q) begin
                        state_d = S_EXEC;
                        if (op_q[7:4] == 4'h3) begin
                            for (int unsigned p = 0; p < NPORT; p++) begin
                                if (op_q[3:0] == 4'(p)) out_pins_d[8*p +: 8] = rx_data;
                            end
                        end
                    end
                end
`ifdef UART_BRIDGE_RXGAP_EN
                else if (gap_q >= 32'(RX_GAP)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
`endif
            end

            S_EXEC: begin
                state_d   = S_IDLE;
                rep_idx_d = '0;
                rep_len_d = 4'd1;
                txph_d    = TX_READY;
                tmo_d     = '0;
                if (op_q == 8'hA0) begin
                    mem_addr_d   = args_q[AW-1:0];
                    mem_wdata_d  = args_q[AW +: DW];
                    mem_wr_req_d = 1'b1;
                    state_d      = S_WAIT_ACK;
                end else if (op_q == 8'hA1) begin
                    mem_addr_d   = args_q[AW-1:0];
                    mem_rd_req_d = 1'b1;
                    state_d      = S_WAIT_ACK;
                end else if (op_q[7:4] == 4'h2) begin
                    rep_d = '0;
                    for (int unsigned p = 0; p < NPORT; p++) begin
                        if (op_q[3:0] == 4'(p)) rep_d[7:0] = in_pins[8*p +: 8];
                    end
                    state_d = S_REPLY;
                end else if (op_q == 8'hFF) begin
                    rep_d      = '0;
                    rep_d[7:0] = 8'hFF;
                    state_d    = S_REPLY;
                end
            end

            S_WAIT_ACK: begin
                // Ack beats timeout when both land on the final wait cycle.
                if (mem_hit || tmo_q == TMO_LAST) begin
                    mem_wr_req_d = 1'b0;
                    mem_rd_req_d = 1'b0;
                    state_d      = S_REPLY;
                    rep_d        = '0;
                    rep_len_d    = mem_rd_req_q ? REP_RD : 4'd1;
                    if (mem_hit) begin
                        if (mem_rd_req_q) rep_d[DW+7:8] = mem_rdata;
                    end else begin
                        rep_d[7:0] = 8'hEE;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_REPLY: begin
                case (txph_q)
                    TX_READY: begin
                        if (!tx_busy) begin
                            tx_en_d = 1'b1;
                            for (int unsigned b = 0; b < DB + 1; b++) begin
                                if (rep_idx_q == 4'(b)) tx_data_d = rep_q[8*b +: 8];
                            end
                            rep_idx_d = rep_idx_q + 4'd1;
                            txph_d    = TX_RISE;
                        end
                    end
                    TX_RISE: begin
                        if (tx_busy) txph_d = TX_FALL;
                    end
                    default: begin
                        if (!tx_busy) begin
                            txph_d = TX_READY;
                            if (rep_idx_q == rep_len_q) state_d = S_IDLE;
                        end
                    end
                endcase
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            cnt_q        <= '0;
            plen_q       <= '0;
            args_q       <= '0;
            tmo_q        <= '0;
            rep_q        <= '0;
            rep_len_q    <= '0;
            rep_idx_q    <= '0;
            txph_q       <= TX_READY;
            tx_en_q      <= 1'b0;
            tx_data_q    <= '0;
            out_clk_q    <= 1'b0;
            out_rst_q    <= 1'b0;
            out_pins_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wr_req_q <= 1'b0;
            mem_rd_req_q <= 1'b0;
`ifdef UART_BRIDGE_RXGAP_EN
            gap_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            plen_q       <= plen_d;
            args_q       <= args_d;
            tmo_q        <= tmo_d;
            rep_q        <= rep_d;
            rep_len_q    <= rep_len_d;
            rep_idx_q    <= rep_idx_d;
            txph_q       <= txph_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
            out_clk_q    <= out_clk_d;
            out_rst_q    <= out_rst_d;
            out_pins_q   <= out_pins_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wr_req_q <= mem_wr_req_d;
            mem_rd_req_q <= mem_rd_req_d;
`ifdef UART_BRIDGE_RXGAP_EN
            gap_q        <= gap_d;
`endif
        end
    end

    assign tx_en      = tx_en_q;
    assign tx_data    = tx_data_q;
    assign out_clk    = out_clk_q;
    assign out_rst    = out_rst_q;
    assign out_pins   = out_pins_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wr_req = mem_wr_req_q;
    assign mem_rd_req = mem_rd_req_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Bench for uart_cmd_bridge: directed frames plus randomized frames scored against a frame-level model.
module tb_uart_cmd_bridge;

    localparam int NPORT   = 8;
    localparam int AW      = 24;
    localparam int DW      = 16;
    localparam int ACK_TMO = 255;
    localparam int RX_GAP  = 50;
    localparam int AB      = AW / 8;
    localparam int DB      = DW / 8;

    logic               sys_clk;
    logic               sys_rst_n;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               tx_en;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic               out_clk;
    logic               out_rst;
    logic [8*NPORT-1:0] in_pins;
    logic [8*NPORT-1:0] out_pins;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               mem_wr_req;
    logic               mem_rd_req;
    logic               mem_wr_ack;
    logic               mem_rd_ack;

    uart_cmd_bridge #(
        .NPORT  (NPORT),
        .AW     (AW),
        .DW     (DW),
        .ACK_TMO(ACK_TMO),
        .RX_GAP (RX_GAP)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .out_clk   (out_clk),
        .out_rst   (out_rst),
        .in_pins   (in_pins),
        .out_pins  (out_pins),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_wr_req(mem_wr_req),
        .mem_rd_req(mem_rd_req),
        .mem_wr_ack(mem_wr_ack),
        .mem_rd_ack(mem_rd_ack)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level model state
    logic [7:0] m_port [NPORT];
    logic       m_clk;
    logic       m_rst;
    logic [7:0] frame_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    // UART transmitter model
    logic hold_busy = 1'b0;
    int   busy_left = 0;
    int   early_tx  = 0;

    // Memory responder configuration and observations
    int            ack_cfg  = 0;   // ack on this request cycle (1-based); 0 = never
    int            ack_mode = 0;   // 0 matching, 1 both acks, 2 only the wrong ack
    logic [DW-1:0] rd_val   = '0;
    int            req_cycles = 0;
    int            last_len   = 0;
    int            req_count  = 0;
    int            unstable   = 0;
    logic [AW-1:0] req_addr   = '0;
    logic [DW-1:0] req_wdata  = '0;
    logic          req_wr     = 1'b0;

    function automatic logic [63:0] exp_pins();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NPORT; i++) v[8*i +: 8] = m_port[i];
        return v;
    endfunction

    function automatic int payload_len(input logic [7:0] op);
        if (op[7:4] == 4'h3 && int'(op[3:0]) < NPORT) return 1;
        if (op == 8'hA0) return AB + DB;
        if (op == 8'hA1) return AB;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NPORT; i++) m_port[i] = 8'h00;
        m_clk = 1'b0;
        m_rst = 1'b0;
    endtask

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (tx_en) begin
                if (tx_busy) early_tx++;
                got_q.push_back(tx_data);
                busy_left = $urandom_range(1, 4);
            end else if (busy_left > 0) begin
                busy_left--;
            end
            tx_busy = hold_busy || (busy_left != 0);
        end
    end

    initial begin
        mem_wr_ack = 1'b0;
        mem_rd_ack = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge sys_clk);
            #1;
            mem_wr_ack = 1'b0;
            mem_rd_ack = 1'b0;
            mem_rdata  = DW'($urandom);
            if (mem_wr_req || mem_rd_req) begin
                if (req_cycles == 0) begin
                    req_addr  = mem_addr;
                    req_wdata = mem_wdata;
                    req_wr    = mem_wr_req;
                end else if (mem_addr !== req_addr || mem_wdata !== req_wdata) begin
                    unstable++;
                end
                req_cycles++;
                if (ack_cfg != 0 && req_cycles == ack_cfg) begin
                    case (ack_mode)
                        0: begin mem_wr_ack = mem_wr_req; mem_rd_ack = mem_rd_req; end
                        1: begin mem_wr_ack = 1'b1;       mem_rd_ack = 1'b1;       end
                        default: begin mem_wr_ack = mem_rd_req; mem_rd_ack = mem_wr_req; end
                    endcase
                    mem_rdata = rd_val;
                end
            end else if (req_cycles != 0) begin
                last_len   = req_cycles;
                req_count++;
                req_cycles = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Sends frame_q, applies the model, then scores pins, reply bytes and any memory request.
    task automatic run_frame(input int inject, input int hold);
        logic [7:0]    op;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            ok;
        bit            is_mem;
        bit            is_wr;
        int            n;
        int            exp_len;
        int            base_reqs;
        int            budget;
        op     = frame_q[0];
        n      = int'(op[3:0]);
        is_mem = 1'b0;
        is_wr  = 1'b0;
        a      = '0;
        d      = '0;
        exp_len = 0;
        exp_q.delete();
        got_q.delete();
        ok = (ack_mode != 2) && (ack_cfg >= 1) && (ack_cfg <= ACK_TMO);
        if (op == 8'h10)      m_clk = 1'b1;
        else if (op == 8'h11) m_clk = 1'b0;
        else if (op == 8'h12) m_rst = 1'b1;
        else if (op == 8'h13) m_rst = 1'b0;
        else if (op[7:4] == 4'h2 && n < NPORT) exp_q.push_back(8'(in_pins >> (8 * n)));
        else if (op[7:4] == 4'h3 && n < NPORT) m_port[n] = frame_q[1];
        else if (op == 8'hA0 || op == 8'hA1) begin
            is_mem = 1'b1;
            is_wr  = (op == 8'hA0);
            for (int i = 0; i < AB; i++) a |= AW'(frame_q[1+i]) << (8 * i);
            if (is_wr) for (int i = 0; i < DB; i++) d |= DW'(frame_q[1+AB+i]) << (8 * i);
            exp_q.push_back(ok ? 8'h00 : 8'hEE);
            if (!is_wr) for (int i = 0; i < DB; i++) exp_q.push_back(ok ? 8'(rd_val >> (8 * i)) : 8'h00);
            exp_len = ok ? ack_cfg : ACK_TMO;
        end else begin
            exp_q.push_back(8'hFF);
        end

        base_reqs = req_count;
        foreach (frame_q[i]) begin
            if (i > 0) repeat ($urandom_range(0, 3)) @(negedge sys_clk);
            send_byte(frame_q[i]);
        end
        check("pins_after_frame", out_pins, exp_pins());
        check("clk_after_frame", out_clk, m_clk);
        check("rst_after_frame", out_rst, m_rst);

        if (inject != 0) begin
            repeat (3) @(posedge sys_clk);
            send_byte(8'h10);
        end
        if (hold != 0) begin
            repeat (hold) @(posedge sys_clk);
            #1;
            check("no_tx_while_busy", got_q.size(), 0);
            hold_busy = 1'b0;
        end

        budget = ACK_TMO + 100;
        while (got_q.size() < exp_q.size() && budget > 0) begin
            @(posedge sys_clk);
            budget--;
        end
        repeat (12) @(posedge sys_clk);
        #1;
        check("reply_count", got_q.size(), exp_q.size());
        foreach (exp_q[i]) check("reply_byte", (i < got_q.size()) ? 64'(got_q[i]) : 64'h100, exp_q[i]);
        if (is_mem) begin
            check("req_count", req_count - base_reqs, 1);
            check("req_kind", req_wr, is_wr);
            check("req_addr", req_addr, a);
            if (is_wr) check("req_wdata", req_wdata, d);
            check("req_len", last_len, exp_len);
        end else begin
            check("req_count", req_count - base_reqs, 0);
        end
        check("pins_final", out_pins, exp_pins());
        check("clk_final", out_clk, m_clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op;
        int         kind;
        sys_rst_n = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        in_pins   = {$urandom, $urandom};
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_clk_rst", {out_clk, out_rst}, 0);
        check("rst_reqs", {mem_wr_req, mem_rd_req}, 0);
        check("rst_pins", out_pins, 0);
        check("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        // Port write lands one cycle after the last byte, no reply
        frame_q = '{8'h33, 8'h5A};
        run_frame(0, 0);

        // Port read
        in_pins[15:8] = 8'hC3;
        frame_q = '{8'h21};
        run_frame(0, 0);

        // Memory write acked after 5 cycles
        ack_cfg = 5; ack_mode = 0;
        frame_q = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h34, 8'h12};
        run_frame(0, 0);

        // Memory read timeout
        ack_cfg = 0;
        frame_q = '{8'hA1, 8'h11, 8'h22, 8'h33};
        run_frame(0, 0);

        // Ack on the last allowed cycle is a success
        ack_cfg = ACK_TMO; rd_val = 16'hBEEF;
        frame_q = '{8'hA1, 8'h44, 8'h55, 8'h66};
        run_frame(0, 0);

        // Simultaneous acks, then only the non-matching ack
        ack_cfg = 7; ack_mode = 1;
        frame_q = '{8'hA0, 8'h9A, 8'hBC, 8'hDE, 8'h01, 8'h80};
        run_frame(0, 0);
        ack_mode = 2;
        frame_q = '{8'hA0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        run_frame(0, 0);
        rd_val = 16'h5AA5;
        frame_q = '{8'hA1, 8'hFE, 8'hDC, 8'hBA};
        run_frame(0, 0);
        ack_mode = 0;

        // Byte arriving while waiting for ack is dropped
        frame_q = '{8'h11};
        run_frame(0, 0);
        ack_cfg = 40; rd_val = 16'h0F0F;
        frame_q = '{8'hA1, 8'h01, 8'h00, 8'h80};
        run_frame(1, 0);

        // Invalid port index with transmitter held busy
        hold_busy = 1'b1;
        repeat (2) @(posedge sys_clk);
        frame_q = '{8'h3F};
        run_frame(0, 10);

        // Stalled payload: abandoned when the gap timer is built in, otherwise completed later
        frame_q = '{8'h10};
        run_frame(0, 0);
        got_q.delete();
        send_byte(8'h30);
        repeat (60) @(posedge sys_clk);
        send_byte(8'h11);
`ifdef UART_BRIDGE_RXGAP_EN
        m_clk = 1'b0;
`else
        m_port[0] = 8'h11;
`endif
        check("gap_pins", out_pins, exp_pins());
        check("gap_clk", out_clk, m_clk);
        repeat (12) @(posedge sys_clk);
        #1;
        check("gap_no_reply", got_q.size(), 0);

        for (int it = 0; it < 60; it++) begin
            in_pins  = {$urandom, $urandom};
            rd_val   = DW'($urandom);
            ack_mode = 0;
            ack_cfg  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            kind     = $urandom_range(0, 5);
            case (kind)
                0: op = 8'h10 + 8'($urandom_range(0, 3));
                1: op = 8'h20 | 8'($urandom_range(0, 15));
                2: op = 8'h30 | 8'($urandom_range(0, 15));
                3: op = 8'hA0;
                4: op = 8'hA1;
                default: op = 8'($urandom);
            endcase
            frame_q = '{op};
            for (int i = 0; i < payload_len(op); i++) frame_q.push_back(8'($urandom));
            run_frame(0, 0);
        end

        // Reset during an outstanding read
        ack_cfg = 0;
        got_q.delete();
        frame_q = '{8'hA1, 8'h0A, 8'h0B, 8'h0C};
        foreach (frame_q[i]) send_byte(frame_q[i]);
        repeat (20) @(posedge sys_clk);
        #1;
        check("req_before_rst", mem_rd_req, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("req_async_drop", mem_rd_req, 0);
        check("pins_async_clr", out_pins, 0);
        model_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1;
        check("no_reply_after_rst", got_q.size(), 0);
        in_pins = {$urandom, $urandom};
        frame_q = '{8'h27};
        run_frame(0, 0);

        check("tx_while_busy", early_tx, 0);
        check("addr_stable", unstable, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 SHALL have parameter NPORT, default 8, meaning the number of 8-bit input ports and the number of 8-bit output ports (1..16).
REQ-002 SHALL have parameter AW, default 24, meaning the memory address width in bits (multiple of 8, 8..32).
REQ-003 SHALL have parameter DW, default 16, meaning the memory data width in bits (multiple of 8, 8..32).
REQ-004 SHALL have parameter ACK_TMO, default 255, meaning the maximum cycles to wait for a memory ack (1..65535).
REQ-005 SHALL have parameter RX_GAP, default 100000, meaning the maximum cycles allowed between frame bytes.
REQ-006 sys_clk  in  1  single clock; all logic rising-edge.
REQ-007 sys_rst_n  in  1  asynchronous active-low reset.
REQ-008 rx_valid  in  1  one-cycle pulse, byte received; rx_data  in  8  received byte.
REQ-009 tx_en  out  1  one-cycle send pulse; tx_data  out  8  byte to send; tx_busy  in  1  UART transmitter busy.
REQ-010 out_clk, out_rst  out  1 each  software-controlled clock and reset lines.
REQ-011 in_pins  in  8*NPORT  input ports, port n = bits [8n+7:8n]; out_pins  out  8*NPORT  output ports, same packing.
REQ-012 mem_addr  out  AW; mem_wdata  out  DW; mem_rdata  in  DW; mem_wr_req, mem_rd_req  out  1 each; mem_wr_ack, mem_rd_ack  in  1 each.

Function
REQ-013 Frame SHALL be opcode byte plus payload bytes; multi-byte fields LSB first.
REQ-014 Opcodes: 0x10/0x11 set/clear out_clk; 0x12/0x13 set/clear out_rst; 0x2n reply in port n; 0x3n + 1 byte write out port n; 0xA0 + AW/8 addr + DW/8 data = memory write; 0xA1 + AW/8 addr = memory read.
REQ-015 Port index n >= NPORT, or any other opcode, SHALL reply single byte 0xFF and change no state.
REQ-016 FSM states SHALL be IDLE, ARGS, EXEC, WAIT_ACK, REPLY; IDLE->ARGS on opcode with payload, IDLE/ARGS->EXEC on last frame byte, EXEC->WAIT_ACK for 0xA0/0xA1, EXEC/WAIT_ACK->REPLY when a reply is owed, else ->IDLE.
REQ-017 Output write and out_clk/out_rst change SHALL take effect one cycle after the last frame byte's rx_valid.
REQ-018 In WAIT_ACK the matching mem_*_req SHALL be held high with mem_addr/mem_wdata stable until ack seen or ACK_TMO cycles elapse; req SHALL drop the cycle after.
REQ-019 Memory write SHALL reply 0x00 on ack, 0xEE on timeout; memory read SHALL reply status byte then DW/8 bytes of mem_rdata captured on the ack cycle (zeros on timeout).
REQ-020 In REPLY, tx_en SHALL pulse only when tx_busy=0 and SHALL not pulse again until tx_busy has risen and fallen.
REQ-021 rx_valid arriving outside IDLE/ARGS SHALL be dropped; the frame parser restarts in IDLE.
REQ-022 Ack asserted on the same cycle the timeout expires SHALL count as success.
REQ-023 Simultaneous mem_wr_ack and mem_rd_ack SHALL only honour the one matching the pending request.

Reset
REQ-024 Reset SHALL force state IDLE; tx_en, out_clk, out_rst, mem_wr_req, mem_rd_req = 0; out_pins, mem_addr, mem_wdata, tx_data = 0.
REQ-025 Reset mid-WAIT_ACK SHALL drop req asynchronously and emit no reply.

Configuration
REQ-026 Macro UART_BRIDGE_RXGAP_EN defined: ARGS exceeding RX_GAP cycles without rx_valid SHALL abandon the frame, return to IDLE, send no reply.
REQ-027 Macro undefined: no gap timer; ARGS SHALL wait indefinitely for payload bytes.

Verification
REQ-028 Bytes 0x33,0x5A -> out_pins[31:24]=0x5A one cycle after second rx_valid, no reply.
REQ-029 in_pins[15:8]=0xC3, byte 0x21 -> single tx_en with tx_data=0xC3.
REQ-030 Defaults: 0xA0,0x01,0x02,0x03,0x34,0x12, ack after 5 cycles -> mem_addr=0x030201, mem_wdata=0x1234, reply 0x00.
REQ-031 0xA1 + 3 addr bytes, no ack -> req high exactly 255 cycles, reply 0xEE,0x00,0x00.
REQ-032 Byte 0x3F with NPORT=8 -> reply 0xFF, out_pins unchanged; tx_busy held high delays tx_en until it falls.
REQ-033 UART_BRIDGE_RXGAP_EN, RX_GAP=50: 0x30 then 60 idle cycles then 0x11 -> out_pins[7:0] unchanged, out_clk=0.
